// File: rtl/tr_output_stage.sv
// Transducer output stage: double-buffered duty/phase per channel, committed at period
// boundaries, with registered PWM/balance drive. Optional slew limiting: TR_OUTPUT_SLEW_EN.

module tr_output_ch #(
    parameter int    CNT_WIDTH      = 9,
    parameter int    DATA_WIDTH     = 8,
    parameter string PHASE_INVERTED = "TRUE"
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [CNT_WIDTH-1:0]  time_i,
    input  logic                  boundary_i,
    input  logic                  update_i,
    input  logic [DATA_WIDTH-1:0] duty_i,
    input  logic [DATA_WIDTH-1:0] phase_i,
    input  logic [DATA_WIDTH-1:0] step_i,
    output logic                  raw_pwm_o,
    output logic                  match_o
);
    localparam int SHIFT = CNT_WIDTH - DATA_WIDTH;
    localparam bit INV   = (PHASE_INVERTED == "TRUE");

    logic [DATA_WIDTH-1:0] sh_duty_q, sh_phase_q;
    logic [DATA_WIDTH-1:0] tg_duty_q, tg_phase_q;
    logic [DATA_WIDTH-1:0] ac_duty_q, ac_phase_q;
    logic [DATA_WIDTH-1:0] ac_duty_d, ac_phase_d;
    logic [DATA_WIDTH-1:0] start_ph;
    logic [CNT_WIDTH-1:0]  start, width, rel;
    logic                  raw_q;

    always_comb begin
        start_ph = INV ? (DATA_WIDTH'(0) - ac_phase_q) : ac_phase_q;
        start    = CNT_WIDTH'(start_ph) << SHIFT;
        width    = CNT_WIDTH'(ac_duty_q) << SHIFT;
        rel      = time_i - start;
    end

`ifdef TR_OUTPUT_SLEW_EN
    logic [DATA_WIDTH-1:0] d_dist, p_fwd, p_rev, p_dist;
    logic                  d_up, p_up;

    // Phase walks the shorter arc; an exact half-turn tie goes positive.
    always_comb begin
        d_up      = tg_duty_q > ac_duty_q;
        d_dist    = d_up ? (tg_duty_q - ac_duty_q) : (ac_duty_q - tg_duty_q);
        ac_duty_d = tg_duty_q;
        if (step_i != '0 && d_dist > step_i)
            ac_duty_d = d_up ? (ac_duty_q + step_i) : (ac_duty_q - step_i);
        p_fwd      = tg_phase_q - ac_phase_q;
        p_rev      = ac_phase_q - tg_phase_q;
        p_up       = p_fwd <= p_rev;
        p_dist     = p_up ? p_fwd : p_rev;
        ac_phase_d = tg_phase_q;
        if (step_i != '0 && p_dist > step_i)
            ac_phase_d = p_up ? (ac_phase_q + step_i) : (ac_phase_q - step_i);
    end
`else
    logic unused_step;
    assign unused_step = ^step_i;
    assign ac_duty_d   = tg_duty_q;
    assign ac_phase_d  = tg_phase_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_duty_q  <= '0;
            sh_phase_q <= '0;
            tg_duty_q  <= '0;
            tg_phase_q <= '0;
            ac_duty_q  <= '0;
            ac_phase_q <= '0;
            raw_q      <= 1'b0;
        end else begin
            if (update_i) begin
                sh_duty_q  <= duty_i;
                sh_phase_q <= phase_i;
            end
            if (boundary_i) begin
                tg_duty_q  <= sh_duty_q;
                tg_phase_q <= sh_phase_q;
                ac_duty_q  <= ac_duty_d;
                ac_phase_q <= ac_phase_d;
            end
            raw_q <= rel < width;
        end
    end

    assign raw_pwm_o = raw_q;
    assign match_o   = (ac_duty_q == tg_duty_q) && (ac_phase_q == tg_phase_q);
endmodule

module tr_output_stage #(
    parameter int    TRANS_NUM      = 249,
    parameter int    CNT_WIDTH      = 9,
    parameter int    DATA_WIDTH     = 8,
    parameter string PHASE_INVERTED = "TRUE"
) (
    input  logic                                  CLK,
    input  logic                                  RST_N,
    input  logic [CNT_WIDTH-1:0]                  TIME,
    input  logic                                  UPDATE,
    input  logic [TRANS_NUM-1:0][DATA_WIDTH-1:0]  DUTY,
    input  logic [TRANS_NUM-1:0][DATA_WIDTH-1:0]  PHASE,
    input  logic [DATA_WIDTH-1:0]                 STEP,
    input  logic                                  OUTPUT_EN,
    input  logic                                  OUTPUT_BALANCE,
    output logic [TRANS_NUM-1:0]                  PWM_OUT,
    output logic                                  SETTLED
);
    logic                 boundary;
    logic [TRANS_NUM-1:0] raw, match;
    logic [TRANS_NUM-1:0] pwm_q;
    logic                 balance_q, balance_d, settled_q;

    assign boundary = (TIME == '1);

    for (genvar g = 0; g < TRANS_NUM; g++) begin : g_ch
        tr_output_ch #(
            .CNT_WIDTH      (CNT_WIDTH),
            .DATA_WIDTH     (DATA_WIDTH),
            .PHASE_INVERTED (PHASE_INVERTED)
        ) u_ch (
            .clk_i      (CLK),
            .rst_ni     (RST_N),
            .time_i     (TIME),
            .boundary_i (boundary),
            .update_i   (UPDATE),
            .duty_i     (DUTY[g]),
            .phase_i    (PHASE[g]),
            .step_i     (STEP),
            .raw_pwm_o  (raw[g]),
            .match_o    (match[g])
        );
    end

    // Balance bypasses the compare stage so enable changes land after one clock.
    assign balance_d = OUTPUT_BALANCE ? ~balance_q : 1'b0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            balance_q <= 1'b0;
            pwm_q     <= '0;
            settled_q <= 1'b1;
        end else begin
            balance_q <= balance_d;
            pwm_q     <= OUTPUT_EN ? raw : {TRANS_NUM{balance_d}};
            settled_q <= &match;
        end
    end

    assign PWM_OUT = pwm_q;
    assign SETTLED = settled_q;
endmodule

// File: doc/tr_output_stage.md
# tr_output_stage

Parametrised per-channel transducer output stage: double-buffers duty/phase per channel, applies new values only at ultrasound-period boundaries, optionally slew-limits duty and phase between periods, and generates the registered PWM/balance drive for every channel. It sits after the modulation/silent/delay chain and drives the transducer output pins directly.

## Interface
- TRANS_NUM, 249: channel count.
- CNT_WIDTH, 9: TIME width; ultrasound period CYCLE = 2^CNT_WIDTH clocks.
- DATA_WIDTH, 8: duty/phase width; must satisfy DATA_WIDTH <= CNT_WIDTH; SHIFT = CNT_WIDTH - DATA_WIDTH.
- PHASE_INVERTED, "TRUE": "TRUE" makes start tick = (-PHASE mod 2^DATA_WIDTH) << SHIFT; otherwise PHASE << SHIFT.
- CLK  in  1  system clock; the single clock.
- RST_N  in  1  asynchronous, active-low reset.
- TIME  in  CNT_WIDTH  free-running period counter, increments by 1 per CLK, wraps CYCLE-1 -> 0.
- UPDATE  in  1  single-cycle strobe: capture DUTY/PHASE into shadow.
- DUTY  in  TRANS_NUM x DATA_WIDTH  requested duty per channel.
- PHASE  in  TRANS_NUM x DATA_WIDTH  requested phase per channel.
- STEP  in  DATA_WIDTH  max per-period change of duty and phase; 0 = unlimited.
- OUTPUT_EN  in  1  1: drive PWM; 0: drive balance signal.
- OUTPUT_BALANCE  in  1  1: balance toggles each CLK; 0: balance held 0.
- PWM_OUT  out  TRANS_NUM  per-channel drive.
- SETTLED  out  1  all channels' active values equal their targets.

## Operation
- Three register sets per channel: shadow (written by UPDATE), target, active (used by PWM).
- UPDATE=1: shadow <= DUTY/PHASE. Independent of TIME.
- Boundary = cycle where TIME == CYCLE-1. At boundary: target <= shadow (pre-edge value); active advances per slew rule (uses pre-edge target). UPDATE on the boundary cycle: shadow captures; value reaches target at next boundary.
- Without slew: active <= target at the boundary after target loads, i.e. active follows target one boundary later.
- Window per channel: s = start tick, w = active_duty << SHIFT. Raw PWM high when ((TIME - s) mod CYCLE) < w. Duty 0 -> never high; duty 2^DATA_WIDTH-1 -> high CYCLE - 2^SHIFT ticks.
- PWM_OUT[i] <= OUTPUT_EN ? raw_pwm[i] : balance.
- balance <= OUTPUT_BALANCE ? ~balance : 0.
- SETTLED registered, updated each CLK: 1 iff active == target for every channel (duty and phase).

## Timing
- Reset (RST_N=0, async): shadow, target, active, balance, PWM_OUT = 0; SETTLED = 1.
- Raw PWM compare registered (1 stage), then output register: PWM_OUT at edge n+2 reflects TIME sampled at edge n.
- UPDATE to active (STEP=0 or macro off): data captured at edge u; active changes at the second boundary after u's edge (target at first, active at second); UPDATE on a boundary cycle counts that boundary as neither.
- OUTPUT_EN/OUTPUT_BALANCE change: seen at PWM_OUT after 1 CLK (not pipelined with compare).
- SETTLED lags active/target changes by 1 CLK.
- Reset release mid-period: no boundary action until TIME next equals CYCLE-1.

## Configuration
- Macro TR_OUTPUT_SLEW_EN.
- Defined: at each boundary, duty: if |target - active| <= STEP (or STEP == 0) active <= target, else active moves STEP toward target. Phase: diff = (target - active) mod 2^DATA_WIDTH; if STEP == 0 or min(diff, 2^DATA_WIDTH - diff) <= STEP, active <= target; else move STEP along shorter arc, wrapping modulo 2^DATA_WIDTH; tie (diff = 2^(DATA_WIDTH-1)) moves positive.
- Not defined: STEP ignored; active <= target at every boundary; no slew logic synthesised.

## Test plan
- Reset: TRANS_NUM=4, assert RST_N=0 mid-period -> PWM_OUT=0, SETTLED=1 immediately; release, OUTPUT_EN=1 -> PWM_OUT stays 0 (duty 0).
- Basic PWM: CNT_WIDTH=9, DATA_WIDTH=8, PHASE_INVERTED="FALSE", duty 64, phase 16 -> PWM_OUT high for TIME 32..159 (128 ticks), seen 2 CLK later; inverted mode -> high TIME 480..95 wrapping.
- Update alignment: UPDATE at TIME=100 then at TIME=511 -> first value active from second boundary; second value one period later; no partial period with mixed values.
- Slew (macro on): STEP=10, active duty 0 -> target 25: per period 10, 20, 25; SETTLED 0 until 25 reached; phase 250 -> 5: 250 -> 4 (+10 wrap) -> 5.
- Phase tie: STEP=1, active 0, target 128 -> moves +1 each period; STEP=0 -> immediate jump, SETTLED 1 within 1 CLK.
- Balance: OUTPUT_EN=0, OUTPUT_BALANCE=1 -> PWM_OUT all channels toggle every CLK in phase; OUTPUT_BALANCE=0 -> all 0.
